// File: rtl/seq_alu_unit_if.sv
// Request/response bundle for seq_alu_unit: operation request toward the ALU,
// result plus flags back to writeback, each side with its own valid/ready pair.
interface seq_alu_unit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic            out_carry;
    logic            out_overflow;
    logic            out_illegal;

    modport master (
        output in_valid, in_op, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_carry, out_overflow, out_illegal
    );

    modport slave (
        input  in_valid, in_op, operand_a, operand_b, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_carry, out_overflow, out_illegal
    );
endinterface

// File: rtl/seq_alu_unit.sv
// Multi-cycle RV integer ALU: base ops in one cycle, MUL/MULHU/DIVU/REMU iteratively.
// Signed DIV/REM (ops 14/15) exist only when SEQ_ALU_SIGNED_DIV_EN is defined.
module seq_alu_unit #(
    parameter int XLEN = 64,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_alu_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;
`ifdef SEQ_ALU_SIGNED_DIV_EN
    localparam logic [3:0] OP_DIV   = 4'd14;
    localparam logic [3:0] OP_REM   = 4'd15;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state, state_nx;
    logic [3:0]             op_q;
    logic [CW-1:0]          cnt;
    logic [XLEN-1:0]        work_hi, work_lo, b_q;
    logic [XLEN-1:0]        hi_nx, lo_nx, it_res;
    logic [XLEN-1:0]        load_a, load_b;
    logic                   accept, in_iter, last_step;

    logic signed [XLEN-1:0] a_s, b_s;
    logic [SHW-1:0]         shamt;
    logic [XLEN:0]          add_ext, sub_ext;
    logic [XLEN-1:0]        sc_res;
    logic                   sc_carry, sc_ovf, sc_ill;

    logic [XLEN:0]          mul_sum, div_shift;
    logic [XLEN-1:0]        div_diff;
    logic                   div_ge;

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    assign a_s     = bus.operand_a;
    assign b_s     = bus.operand_b;
    assign shamt   = bus.operand_b[SHW-1:0];
    assign add_ext = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    assign sub_ext = {1'b0, bus.operand_a} + {1'b0, ~bus.operand_b} + {{XLEN{1'b0}}, 1'b1};

`ifdef SEQ_ALU_SIGNED_DIV_EN
    assign in_iter = (bus.in_op >= OP_MUL);
`else
    assign in_iter = (bus.in_op >= OP_MUL) && (bus.in_op <= OP_REMU);
`endif

    assign accept    = (state == IDLE) && bus.in_valid;
    assign last_step = (state == BUSY) && (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nx = in_iter ? BUSY : DONE;
            end
            BUSY: if (cnt == CW'(1)) state_nx = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Single-cycle ops, evaluated straight from the request bus at accept
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_ill   = 1'b0;
        case (bus.in_op)
            OP_ADD: begin
                sc_res   = add_ext[XLEN-1:0];
                sc_carry = add_ext[XLEN];
                sc_ovf   = add_ovf(a_s[XLEN-1], b_s[XLEN-1], add_ext[XLEN-1]);
            end
            OP_SUB: begin
                sc_res   = sub_ext[XLEN-1:0];
                sc_carry = sub_ext[XLEN];
                sc_ovf   = sub_ovf(a_s[XLEN-1], b_s[XLEN-1], sub_ext[XLEN-1]);
            end
            OP_AND:  sc_res = bus.operand_a & bus.operand_b;
            OP_OR:   sc_res = bus.operand_a | bus.operand_b;
            OP_XOR:  sc_res = bus.operand_a ^ bus.operand_b;
            OP_SLL:  sc_res = bus.operand_a << shamt;
            OP_SRL:  sc_res = bus.operand_a >> shamt;
            OP_SRA:  sc_res = $unsigned(a_s >>> shamt);
            OP_SLT:  sc_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: sc_res = {{(XLEN-1){1'b0}}, (bus.operand_a < bus.operand_b)};
            default: sc_ill = !in_iter;
        endcase
    end

`ifdef SEQ_ALU_SIGNED_DIV_EN
    logic neg_q, a_neg_q;

    // Signed divide runs on magnitudes; signs are reapplied on the final step
    always_comb begin
        load_a = bus.operand_a;
        load_b = bus.operand_b;
        if (bus.in_op[3:1] == 3'b111) begin
            if (a_s[XLEN-1]) load_a = -bus.operand_a;
            if (b_s[XLEN-1]) load_b = -bus.operand_b;
        end
    end
`else
    assign load_a = bus.operand_a;
    assign load_b = bus.operand_b;
`endif

    // One shift-add or restoring-divide step on the {work_hi, work_lo} pair
    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        div_shift = {work_hi, work_lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift[XLEN-1:0] - b_q;
        if (op_q[3:2] == 2'b10) begin
            hi_nx = mul_sum[XLEN:1];
            lo_nx = {mul_sum[0], work_lo[XLEN-1:1]};
        end else begin
            hi_nx = div_ge ? div_diff : div_shift[XLEN-1:0];
            lo_nx = {work_lo[XLEN-2:0], div_ge};
        end
        case (op_q)
            OP_MUL, OP_DIVU:   it_res = lo_nx;
            OP_MULHU, OP_REMU: it_res = hi_nx;
`ifdef SEQ_ALU_SIGNED_DIV_EN
            // Divide-by-zero keeps the all-ones quotient unsigned-looking
            OP_DIV:  it_res = (neg_q && (b_q != '0)) ? -lo_nx : lo_nx;
            OP_REM:  it_res = a_neg_q ? -hi_nx : hi_nx;
`endif
            default: it_res = lo_nx;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q             <= '0;
            cnt              <= '0;
            work_hi          <= '0;
            work_lo          <= '0;
            b_q              <= '0;
            bus.out_result   <= '0;
            bus.out_zero     <= 1'b0;
            bus.out_carry    <= 1'b0;
            bus.out_overflow <= 1'b0;
            bus.out_illegal  <= 1'b0;
`ifdef SEQ_ALU_SIGNED_DIV_EN
            neg_q            <= 1'b0;
            a_neg_q          <= 1'b0;
`endif
        end else if (accept) begin
            op_q <= bus.in_op;
            if (in_iter) begin
                cnt     <= CW'(XLEN);
                work_hi <= '0;
                work_lo <= load_a;
                b_q     <= load_b;
`ifdef SEQ_ALU_SIGNED_DIV_EN
                neg_q   <= a_s[XLEN-1] ^ b_s[XLEN-1];
                a_neg_q <= a_s[XLEN-1];
`endif
            end else begin
                bus.out_result   <= sc_res;
                bus.out_zero     <= (sc_res == '0);
                bus.out_carry    <= sc_carry;
                bus.out_overflow <= sc_ovf;
                bus.out_illegal  <= sc_ill;
            end
        end else if (state == BUSY) begin
            cnt     <= cnt - CW'(1);
            work_hi <= hi_nx;
            work_lo <= lo_nx;
            if (last_step) begin
                bus.out_result   <= it_res;
                bus.out_zero     <= (it_res == '0);
                bus.out_carry    <= 1'b0;
                bus.out_overflow <= 1'b0;
                bus.out_illegal  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu_unit.sv
// Self-checking bench for seq_alu_unit: directed corner cases plus random ops
// compared against a plain-arithmetic reference model.
module tb_seq_alu_unit;
    localparam int XLEN = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    seq_alu_unit_if #(.XLEN(XLEN)) bus ();

    seq_alu_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
        total = total + 1;
        assert (obs === req) passed = passed + 1;
        else begin
            failed = failed + 1;
            $error("FAIL %s: observed %h required %h", tag, obs, req);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic c, output logic v,
                                  output logic ill, output int lat);
        logic signed [64:0] wide;
        logic [127:0]       p;
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0; lat = 1;
        case (op)
            4'd0: begin
                {c, r} = {1'b0, a} + {1'b0, b};
                wide = $signed({a[63], a}) + $signed({b[63], b});
                v = (wide[64] != wide[63]);
            end
            4'd1: begin
                r = a - b;
                c = (a >= b);
                wide = $signed({a[63], a}) - $signed({b[63], b});
                v = (wide[64] != wide[63]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[5:0];
            4'd6: r = a >> b[5:0];
            4'd7: r = $unsigned($signed(a) >>> b[5:0]);
            4'd8: r = {63'd0, ($signed(a) < $signed(b))};
            4'd9: r = {63'd0, (a < b)};
            4'd10: begin p = {64'd0, a} * {64'd0, b}; r = p[63:0];   lat = XLEN + 1; end
            4'd11: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; lat = XLEN + 1; end
            4'd12: begin r = (b == 0) ? '1 : a / b; lat = XLEN + 1; end
            4'd13: begin r = (b == 0) ? a : a % b;  lat = XLEN + 1; end
`ifdef SEQ_ALU_SIGNED_DIV_EN
            4'd14: begin
                lat = XLEN + 1;
                if (b == 0) r = '1;
                else if (a == {1'b1, 63'd0} && b == '1) r = a;
                else r = $unsigned($signed(a) / $signed(b));
            end
            4'd15: begin
                lat = XLEN + 1;
                if (b == 0) r = a;
                else if (a == {1'b1, 63'd0} && b == '1) r = '0;
                else r = $unsigned($signed(a) % $signed(b));
            end
`else
            4'd14, 4'd15: ill = 1'b1;
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic logic [63:0] rnd_val();
        logic [63:0] x;
        case ($urandom_range(0, 5))
            0:       x = 64'd0;
            1:       x = 64'($urandom_range(1, 20));
            2:       x = '1;
            3:       x = {1'b1, 63'd0};
            default: x = {$urandom, $urandom};
        endcase
        return x;
    endfunction

    // One transaction: accept, wait for result, hold in DONE for 'hold' cycles, hand off.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input int hold);
        logic [63:0] r;
        logic        c, v, ill, rdy_seen;
        int          lat, edges;
        model(op, a, b, r, c, v, ill, lat);
        check({tag, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_op     = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clk); #1;
        edges = 1;
        rdy_seen = 1'b0;
        bus.in_op     = 4'($urandom_range(0, 15));
        bus.operand_a = {$urandom, $urandom};
        bus.operand_b = {$urandom, $urandom};
        while (!bus.out_valid && edges < 200) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        bus.in_valid = 1'b0;
        check({tag, " latency"}, 64'(edges), 64'(lat));
        check({tag, " in_ready busy"}, 64'(rdy_seen), 64'd0);
        check({tag, " zero"}, 64'(bus.out_zero), 64'(r == 64'd0));
        check({tag, " carry"}, 64'(bus.out_carry), 64'(c));
        check({tag, " overflow"}, 64'(bus.out_overflow), 64'(v));
        check({tag, " illegal"}, 64'(bus.out_illegal), 64'(ill));
        for (int i = 0; i <= hold; i++) begin
            check({tag, " result"}, bus.out_result, r);
            check({tag, " in_ready done"}, 64'(bus.in_ready), 64'd0);
            if (i < hold) begin
                bus.operand_a = {$urandom, $urandom};
                @(posedge clk); #1;
            end
        end
        if (hold > 0) begin
            check({tag, " held valid"}, 64'(bus.out_valid), 64'd1);
            check({tag, " held flags"}, {60'd0, bus.out_zero, bus.out_carry, bus.out_overflow, bus.out_illegal},
                  {60'd0, (r == 64'd0), c, v, ill});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, " in_ready back"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.out_ready = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset result", bus.out_result, 64'd0);
        check("reset flags", {60'd0, bus.out_zero, bus.out_carry, bus.out_overflow, bus.out_illegal}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_ovf",  4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        run_op("sub_5_7",  4'd1, 64'd5, 64'd7, 0);
        run_op("sub_7_5",  4'd1, 64'd7, 64'd5, 0);
        run_op("slt",      4'd8, '1, 64'd1, 0);
        run_op("sltu",     4'd9, '1, 64'd1, 0);
        run_op("sra_63",   4'd7, 64'h8000_0000_0000_0000, 64'd63, 0);
        run_op("sll_64",   4'd5, 64'd1, 64'h40, 0);
        run_op("mul",      4'd10, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 0);
        run_op("mulhu",    4'd11, '1, 64'd2, 0);
        run_op("divu",     4'd12, 64'd100, 64'd7, 0);
        run_op("remu",     4'd13, 64'd100, 64'd7, 0);
        run_op("divu_z",   4'd12, 64'd9, 64'd0, 0);
        run_op("remu_z",   4'd13, 64'd9, 64'd0, 10);
        run_op("xor_bp",   4'd4, 64'hA5A5_0000_FFFF_1234, 64'hA5A5_0000_FFFF_1234, 10);

        // Reset in the middle of a multiply
        bus.in_valid  = 1'b1;
        bus.in_op     = 4'd10;
        bus.operand_a = 64'd12345;
        bus.operand_b = 64'd678;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("midrst busy", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst result", bus.out_result, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst out_valid", 64'(bus.out_valid), 64'd0);
        check("postrst in_ready", 64'(bus.in_ready), 64'd1);
        run_op("add_2_3",  4'd0, 64'd2, 64'd3, 0);

        run_op("div_m7_2", 4'd14, -64'sd7, 64'd2, 0);
        run_op("rem_m7_2", 4'd15, -64'sd7, 64'd2, 0);
        run_op("div_ovf",  4'd14, 64'h8000_0000_0000_0000, '1, 0);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] rop;
            rop = 4'($urandom_range(0, 15));
            run_op($sformatf("rnd%0d_op%0d", n, rop), rop, rnd_val(), rnd_val(), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
